// File: rtl/a_plus_b_join_adder_pkg.sv
// Shared constants for the a+b join adder slice.
package a_plus_b_join_adder_pkg;

  localparam int unsigned default_width = 8;

endpackage

// File: rtl/a_plus_b_join_adder_if.sv
// Operand A/B input streams and sum output stream of the a+b join adder.
interface a_plus_b_join_adder_if
  import a_plus_b_join_adder_pkg::*;
#(
  parameter int unsigned width = default_width
);

  logic             a_valid;
  logic             a_ready;
  logic [width-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [width-1:0] b_data;
  logic             sum_valid;
  logic             sum_ready;
  logic [width:0]   sum_data;

  // master: operand FIFOs plus result sink; slave: the join adder
  modport master (
    output a_valid, a_data, b_valid, b_data, sum_ready,
    input  a_ready, b_ready, sum_valid, sum_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, sum_ready,
    output a_ready, b_ready, sum_valid, sum_data
  );

endinterface

// File: rtl/a_plus_b_join_adder_skid.sv
// Valid/ready output stage: 2-entry skid buffer (skid_en=1) or single register (skid_en=0).
module a_plus_b_join_adder_skid #(
  parameter int unsigned width   = 9,
  parameter bit          skid_en = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [width-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data
);

  logic             main_valid;
  logic             skid_valid;
  logic [width-1:0] main_data;
  logic [width-1:0] skid_data;
  logic             push;
  logic             pop;

  // Skid mode takes ready from a flop only; plain mode needs down_ready combinationally.
  always_comb begin
    up_ready   = skid_en ? ~skid_valid : (~main_valid | down_ready);
    push       = up_valid & up_ready;
    pop        = main_valid & down_ready;
    down_valid = main_valid;
    down_data  = main_data;
  end

  // Skid is loaded only on push into a full, stalled main; in plain mode that never happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (pop && skid_valid) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end else if (push && (pop || !main_valid)) begin
      main_valid <= 1'b1;
      main_data  <= up_data;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= up_data;
    end else if (pop) begin
      main_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/a_plus_b_join_adder.sv
// Joins one A and one B token and emits their width+1 bit sum; A_PLUS_B_JOIN_SKID_EN selects a skid output stage.
module a_plus_b_join_adder
  import a_plus_b_join_adder_pkg::*;
#(
  parameter int unsigned width = default_width
) (
  input logic clk,
  input logic rst,
  a_plus_b_join_adder_if.slave io
);

`ifdef A_PLUS_B_JOIN_SKID_EN
  localparam bit use_skid = 1'b1;
`else
  localparam bit use_skid = 1'b0;
`endif

  logic           space;
  logic           consume;
  logic [width:0] sum;

  // Each ready depends only on the other side's valid, so both tokens leave together.
  always_comb begin
    io.a_ready = io.b_valid & space & ~rst;
    io.b_ready = io.a_valid & space & ~rst;
    consume    = io.a_valid & io.b_valid & space & ~rst;
    sum        = {1'b0, io.a_data} + {1'b0, io.b_data};
  end

  a_plus_b_join_adder_skid #(
    .width   (width + 1),
    .skid_en (use_skid)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (consume),
    .up_ready   (space),
    .up_data    (sum),
    .down_valid (io.sum_valid),
    .down_ready (io.sum_ready),
    .down_data  (io.sum_data)
  );

endmodule

// File: tb/tb_a_plus_b_join_adder.sv
// Self-checking bench for a_plus_b_join_adder (default and A_PLUS_B_JOIN_SKID_EN builds).
module tb_a_plus_b_join_adder;

`ifdef A_PLUS_B_JOIN_SKID_EN
  localparam bit skid = 1'b1;
`else
  localparam bit skid = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  a_plus_b_join_adder_if #(.width(8)) io ();

  a_plus_b_join_adder #(.width(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic test_reset();
    rst = 1'b1;
    io.a_valid = 1'b1; io.b_valid = 1'b1;
    io.a_data = 8'd1; io.b_data = 8'd2; io.sum_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (io.sum_valid !== 1'b0) begin
        miscompares++; $display("FAIL reset_sum_valid got %b want 0", io.sum_valid);
      end
      vectors++;
      if ({io.a_ready, io.b_ready} !== 2'b00) begin
        miscompares++; $display("FAIL reset_readies got %b want 00", {io.a_ready, io.b_ready});
      end
      vectors++;
      if (io.sum_data !== 9'd0) begin
        miscompares++; $display("FAIL reset_sum_data got %h want 000", io.sum_data);
      end
    end
    rst = 1'b0; #1;
    vectors++;
    if ({io.a_ready, io.b_ready} !== 2'b11) begin
      miscompares++; $display("FAIL release_readies got %b want 11", {io.a_ready, io.b_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b1 || io.sum_data !== 9'd3) begin
      miscompares++; $display("FAIL release_consume got v=%b d=%0d want v=1 d=3", io.sum_valid, io.sum_data);
    end
    io.a_valid = 1'b0; io.b_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b0) begin
      miscompares++; $display("FAIL release_drain got %b want 0", io.sum_valid);
    end
  endtask

  task automatic test_basic();
    io.a_valid = 1'b1; io.b_valid = 1'b1; io.a_data = 8'd3; io.b_data = 8'd4; io.sum_ready = 1'b1;
    #1;
    vectors++;
    if ({io.a_ready, io.b_ready} !== 2'b11) begin
      miscompares++; $display("FAIL basic_readies got %b want 11", {io.a_ready, io.b_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b1 || io.sum_data !== 9'd7) begin
      miscompares++; $display("FAIL basic_sum got v=%b d=%0d want v=1 d=7", io.sum_valid, io.sum_data);
    end
    io.a_valid = 1'b0; io.b_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_drain got %b want 0", io.sum_valid);
    end
  endtask

  task automatic test_lone_operand();
    io.a_valid = 1'b1; io.a_data = 8'd5; io.b_valid = 1'b0; io.b_data = 8'd0; io.sum_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++;
      if (io.a_ready !== 1'b0 || io.b_ready !== 1'b1) begin
        miscompares++; $display("FAIL lone_readies cycle %0d got a=%b b=%b want a=0 b=1", i, io.a_ready, io.b_ready);
      end
      vectors++;
      if (io.sum_valid !== 1'b0) begin
        miscompares++; $display("FAIL lone_no_output cycle %0d got %b want 0", i, io.sum_valid);
      end
      @(posedge clk); #1;
    end
    io.b_valid = 1'b1; io.b_data = 8'd6;
    #1;
    vectors++;
    if (io.a_ready !== 1'b1) begin
      miscompares++; $display("FAIL lone_join_ready got %b want 1", io.a_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b1 || io.sum_data !== 9'd11) begin
      miscompares++; $display("FAIL lone_sum got v=%b d=%0d want v=1 d=11", io.sum_valid, io.sum_data);
    end
    io.a_valid = 1'b0; io.b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_carry();
    logic [7:0] ta [3] = '{8'hFF, 8'h00, 8'hFF};
    logic [7:0] tb [3] = '{8'hFF, 8'h00, 8'h01};
    logic [8:0] te [3] = '{9'h1FE, 9'h000, 9'h100};
    io.sum_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io.a_valid = 1'b1; io.b_valid = 1'b1; io.a_data = ta[i]; io.b_data = tb[i];
      @(posedge clk); #1;
      vectors++;
      if (io.sum_valid !== 1'b1 || io.sum_data !== te[i]) begin
        miscompares++; $display("FAIL carry_%0d got v=%b d=%h want v=1 d=%h", i, io.sum_valid, io.sum_data, te[i]);
      end
    end
    io.a_valid = 1'b0; io.b_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    io.sum_ready = 1'b0; io.a_valid = 1'b1; io.b_valid = 1'b1; io.a_data = 8'd10; io.b_data = 8'd20;
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b1 || io.sum_data !== 9'd30) begin
      miscompares++; $display("FAIL midflight_load got v=%b d=%0d want v=1 d=30", io.sum_valid, io.sum_data);
    end
    rst = 1'b1; #1;
    vectors++;
    if ({io.a_ready, io.b_ready} !== 2'b00) begin
      miscompares++; $display("FAIL midflight_gate got %b want 00", {io.a_ready, io.b_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b0) begin
      miscompares++; $display("FAIL midflight_discard got %b want 0", io.sum_valid);
    end
    rst = 1'b0; io.a_valid = 1'b0; io.b_valid = 1'b0; io.sum_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (io.sum_valid !== 1'b0) begin
      miscompares++; $display("FAIL midflight_no_consume got %b want 0", io.sum_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] held [$];
    logic [8:0] last_data = '0;
    bit         stalled = 1'b0;
    bit         space, take, pop;
    int         k = 0;
    int         popped = 0;
    int         cyc = 0;
    while (popped < 20 && cyc < 400) begin
      io.a_valid = (k < 20) && ($urandom_range(0, 3) != 0);
      io.b_valid = (k < 20) && ($urandom_range(0, 3) != 0);
      io.a_data = 8'(k + 1);
      io.b_data = 8'(100 + k);
      if (cyc < 40) io.sum_ready = 1'($urandom_range(0, 1));
      else io.sum_ready = (cyc >= 45);
      @(negedge clk);
      space = skid ? (held.size() < 2) : (held.size() == 0 || io.sum_ready);
      vectors++;
      if (io.a_ready !== (io.b_valid & space) || io.b_ready !== (io.a_valid & space)) begin
        miscompares++;
        $display("FAIL bp_readies cycle %0d got a=%b b=%b want a=%b b=%b held=%0d", cyc,
                 io.a_ready, io.b_ready, io.b_valid & space, io.a_valid & space, held.size());
      end
      vectors++;
      if (io.sum_valid !== (held.size() != 0)) begin
        miscompares++; $display("FAIL bp_sum_valid cycle %0d got %b want %b", cyc, io.sum_valid, held.size() != 0);
      end
      if (held.size() != 0) begin
        vectors++;
        if (io.sum_data !== held[0]) begin
          miscompares++; $display("FAIL bp_order cycle %0d got %0d want %0d", cyc, io.sum_data, held[0]);
        end
      end
      if (stalled) begin
        vectors++;
        if (io.sum_data !== last_data) begin
          miscompares++; $display("FAIL bp_stable cycle %0d got %0d want %0d", cyc, io.sum_data, last_data);
        end
      end
      take = io.a_valid & io.b_valid & space;
      pop = (held.size() != 0) && io.sum_ready;
      stalled = (held.size() != 0) && !io.sum_ready;
      last_data = io.sum_data;
      if (pop) begin
        vectors++;
        if (held[0] !== 9'(101 + 2 * popped)) begin
          miscompares++; $display("FAIL bp_sequence pop %0d got %0d want %0d", popped, held[0], 101 + 2 * popped);
        end
        void'(held.pop_front());
        popped++;
      end
      if (take) begin
        held.push_back(9'(io.a_data) + 9'(io.b_data));
        k++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    vectors++;
    if (popped != 20) begin
      miscompares++; $display("FAIL bp_count got %0d want 20 (cycle budget expired)", popped);
    end
    io.a_valid = 1'b0; io.b_valid = 1'b0; io.sum_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    logic [8:0] q [$];
    logic [7:0] av, bv;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    io.sum_ready = 1'b1;
    while (got < 32 && cyc < 100) begin
      av = 8'($urandom); bv = 8'($urandom);
      io.a_valid = (sent < 32); io.b_valid = (sent < 32);
      io.a_data = av; io.b_data = bv;
      @(negedge clk);
      if (sent < 32) begin
        vectors++;
        if (io.a_ready !== 1'b1 || io.b_ready !== 1'b1) begin
          miscompares++; $display("FAIL tp_ready cycle %0d got a=%b b=%b want 1 1", cyc, io.a_ready, io.b_ready);
        end
      end
      if (io.sum_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0 || io.sum_data !== q[0]) begin
          miscompares++; $display("FAIL tp_data cycle %0d got %h want %h", cyc, io.sum_data, (q.size() != 0) ? q[0] : 9'h0);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (sent < 32 && io.a_ready === 1'b1 && io.b_ready === 1'b1) begin
        q.push_back(9'(av) + 9'(bv));
        sent++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    io.a_valid = 1'b0; io.b_valid = 1'b0;
    vectors++;
    if (got != 32 || cyc != 33) begin
      miscompares++; $display("FAIL tp_cycles got %0d sums in %0d cycles want 32 in 33", got, cyc);
    end
  endtask

  initial begin
    io.a_valid = 1'b0; io.b_valid = 1'b0; io.a_data = '0; io.b_data = '0; io.sum_ready = 1'b1;
    test_reset();
    test_basic();
    test_lone_operand();
    test_carry();
    test_reset_midflight();
    test_backpressure();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
